// File: rtl/fetch_seq_ctrl.sv
// Fetch front-end sequencer: arbitrates trap/branch/jump redirects, stall and halt into
// registered PC-generator controls. Optional FETCH_SEQ_PERF_EN adds redirect/stall counters.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module fetch_seq_ctrl #(
  parameter int unsigned PC_WIDTH     = `PC_WIDTH,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trap_req,
  input  logic                br_req,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                jmp_req,
  input  logic [PC_WIDTH-1:0] jmp_target,
  input  logic                stall_req,
  input  logic                halt_req,
  input  logic                resume_req,
  output logic                pc_jump,
  output logic [PC_WIDTH-1:0] pc_target,
  output logic                pc_hold,
  output logic                flush_if,
  output logic                fetch_valid,
  output logic                misalign_err
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]         perf_redirects,
  output logic [31:0]         perf_stall_cycles
`endif
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [PC_WIDTH-1:0] TRAP_PC   = PC_WIDTH'(TRAP_VECTOR);
  localparam logic [3:0]          FLUSH_LEN = 4'(FLUSH_CYCLES);

  logic [1:0]          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                halt_pend_q, halt_pend_d;
  logic                pc_jump_q, pc_jump_d;
  logic [PC_WIDTH-1:0] pc_target_q, pc_target_d;
  logic                pc_hold_q, pc_hold_d;
  logic                flush_if_q, flush_if_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic                misalign_q, misalign_d;
  logic                redir;
  logic [PC_WIDTH-1:0] redir_tgt;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    halt_pend_d = halt_pend_q;
    pc_jump_d   = 1'b0;
    pc_target_d = pc_target_q;
    flush_if_d  = 1'b0;
    misalign_d  = 1'b0;
    redir       = 1'b0;
    redir_tgt   = TRAP_PC;

    case (state_q)
      RUN, STALL: begin
        if (trap_req) begin
          redir = 1'b1;
        end else if (halt_req) begin
          state_d = HALT;
        end else if (br_req) begin
          redir     = 1'b1;
          redir_tgt = br_target;
        end else if (jmp_req) begin
          redir     = 1'b1;
          redir_tgt = jmp_target;
        end else begin
          state_d = stall_req ? STALL : RUN;
        end
      end
      FLUSH: begin
        if (trap_req) begin
          redir = 1'b1;
        end else begin
          // A halt seen mid-flush is remembered and taken once the bubbles drain.
          if (halt_req) halt_pend_d = 1'b1;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            cnt_d       = '0;
            halt_pend_d = 1'b0;
            if (halt_pend_q || halt_req) state_d = HALT;
            else if (stall_req)          state_d = STALL;
            else                         state_d = RUN;
          end
        end
      end
      HALT: begin
        if (trap_req) begin
          redir = 1'b1;
        end else if (resume_req && !halt_req) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (redir) begin
      pc_jump_d   = 1'b1;
      flush_if_d  = 1'b1;
      pc_target_d = {redir_tgt[PC_WIDTH-1:2], 2'b00};
      misalign_d  = |redir_tgt[1:0];
      state_d     = FLUSH;
      cnt_d       = FLUSH_LEN;
    end

    pc_hold_d     = (state_d == STALL) || (state_d == HALT);
    fetch_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      halt_pend_q   <= 1'b0;
      pc_jump_q     <= 1'b0;
      pc_target_q   <= '0;
      pc_hold_q     <= 1'b0;
      flush_if_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      halt_pend_q   <= halt_pend_d;
      pc_jump_q     <= pc_jump_d;
      pc_target_q   <= pc_target_d;
      pc_hold_q     <= pc_hold_d;
      flush_if_q    <= flush_if_d;
      fetch_valid_q <= fetch_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  assign pc_jump      = pc_jump_q;
  assign pc_target    = pc_target_q;
  assign pc_hold      = pc_hold_q;
  assign flush_if     = flush_if_q;
  assign fetch_valid  = fetch_valid_q;
  assign misalign_err = misalign_q;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_redir_q, perf_redir_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_redir_d = perf_redir_q;
    perf_stall_d = perf_stall_q;
    if (pc_jump_q && (perf_redir_q != '1)) perf_redir_d = perf_redir_q + 32'd1;
    if ((state_q == STALL) && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_redir_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_redir_q <= perf_redir_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_redirects    = perf_redir_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Scoreboard bench for fetch_seq_ctrl: directed scenarios then random stimulus, each edge's
// expected response pushed by the stimulus process and checked by an independent monitor.
module tb_fetch_seq_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned FC = 2;
  localparam logic [W-1:0] TV = 32'h0000_0100;

  logic         clk = 1'b0;
  logic         rst, trap_req, br_req, jmp_req, stall_req, halt_req, resume_req;
  logic [W-1:0] br_target, jmp_target;
  logic         pc_jump, pc_hold, flush_if, fetch_valid, misalign_err;
  logic [W-1:0] pc_target;

  fetch_seq_ctrl #(.PC_WIDTH(W), .FLUSH_CYCLES(FC), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .rst(rst), .trap_req(trap_req), .br_req(br_req), .br_target(br_target),
    .jmp_req(jmp_req), .jmp_target(jmp_target), .stall_req(stall_req),
    .halt_req(halt_req), .resume_req(resume_req), .pc_jump(pc_jump),
    .pc_target(pc_target), .pc_hold(pc_hold), .flush_if(flush_if),
    .fetch_valid(fetch_valid), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         jump;
    logic [W-1:0] tgt;
    logic         hold;
    logic         flush;
    logic         valid;
    logic         mis;
  } resp_t;

  resp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: pipeline "mode" described by counters and flags.
  int           m_bubbles;
  bit           m_halted, m_stalled, m_halt_pending;
  logic [W-1:0] m_tgt;

  function automatic resp_t take_redirect(input logic [W-1:0] t);
    resp_t r;
    r = '0;
    r.jump  = 1'b1;
    r.flush = 1'b1;
    r.tgt   = (t / 4) * 4;
    r.mis   = (t % 4) != 0;
    m_tgt     = r.tgt;
    m_bubbles = FC;
    m_stalled = 0;
    m_halted  = 0;
    return r;
  endfunction

  function automatic resp_t model_step();
    resp_t r;
    r = '0;
    if (rst) begin
      m_bubbles = 0; m_halted = 0; m_stalled = 0; m_halt_pending = 0; m_tgt = '0;
      return r;
    end
    if (m_bubbles > 0) begin
      if (trap_req) r = take_redirect(TV);
      else begin
        if (halt_req) m_halt_pending = 1;
        m_bubbles = m_bubbles - 1;
        if (m_bubbles == 0) begin
          if (m_halt_pending) m_halted = 1;
          else m_stalled = stall_req;
          m_halt_pending = 0;
        end
      end
    end else if (m_halted) begin
      if (trap_req) r = take_redirect(TV);
      else if (resume_req && !halt_req) m_halted = 0;
    end else begin
      if (trap_req) r = take_redirect(TV);
      else if (halt_req) begin m_halted = 1; m_stalled = 0; end
      else if (br_req) r = take_redirect(br_target);
      else if (jmp_req) r = take_redirect(jmp_target);
      else m_stalled = stall_req;
    end
    r.tgt   = m_tgt;
    r.hold  = (m_bubbles == 0) && (m_halted || m_stalled);
    r.valid = (m_bubbles == 0) && !m_halted && !m_stalled;
    return r;
  endfunction

  task automatic step(input bit rs, input bit tr, input bit hl, input bit rsm,
                      input bit br, input logic [W-1:0] bt,
                      input bit jp, input logic [W-1:0] jt, input bit st);
    @(negedge clk);
    rst = rs; trap_req = tr; halt_req = hl; resume_req = rsm;
    br_req = br; br_target = bt; jmp_req = jp; jmp_target = jt; stall_req = st;
    exp_q.push_back(model_step());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0, 0, '0, 0);
  endtask

  // Monitor: every edge produces one response from the DUT.
  initial begin
    resp_t e, a;
    int cyc;
    cyc = 0;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      a = '{jump: pc_jump, tgt: pc_target, hold: pc_hold, flush: flush_if,
            valid: fetch_valid, mis: misalign_err};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL resp_underflow cyc=%0d no expected entry", cyc);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL resp cyc=%0d got j=%b t=%h h=%b f=%b v=%b m=%b want j=%b t=%h h=%b f=%b v=%b m=%b",
                   cyc, a.jump, a.tgt, a.hold, a.flush, a.valid, a.mis,
                   e.jump, e.tgt, e.hold, e.flush, e.valid, e.mis);
        end
      end
    end
  end

  initial begin
    rst = 1; trap_req = 0; halt_req = 0; resume_req = 0; br_req = 0; jmp_req = 0;
    stall_req = 0; br_target = '0; jmp_target = '0;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, '0, 0, '0, 0);
    idle(3);
    step(0, 0, 0, 0, 1, 32'h40, 0, '0, 0);           // branch to 0x40
    idle(4);
    step(0, 1, 0, 0, 1, 32'h40, 1, 32'h80, 0);       // trap beats branch and jump
    idle(4);
    step(0, 0, 0, 0, 0, '0, 0, '0, 1);               // stall, branch on 2nd stall cycle
    step(0, 0, 0, 0, 1, 32'h20, 0, '0, 1);
    step(0, 0, 0, 0, 0, '0, 0, '0, 1);
    idle(4);
    step(0, 0, 0, 0, 0, '0, 1, 32'h43, 0);           // misaligned jump
    idle(4);
    step(0, 0, 1, 0, 0, '0, 0, '0, 0);               // halt, branch ignored, resume
    step(0, 0, 0, 0, 1, 32'h60, 0, '0, 0);
    step(0, 0, 1, 1, 0, '0, 0, '0, 0);
    step(0, 0, 0, 1, 0, '0, 0, '0, 0);
    idle(2);
    step(0, 0, 0, 0, 1, 32'h84, 0, '0, 0);           // trap on first bubble re-redirects
    step(0, 1, 0, 0, 0, '0, 0, '0, 0);
    idle(4);
    step(0, 0, 0, 0, 0, '0, 1, 32'h90, 0);           // halt during flush, then reset mid-flush
    step(0, 0, 1, 0, 0, '0, 0, '0, 0);
    idle(3);
    step(0, 0, 0, 1, 0, '0, 0, '0, 0);
    step(0, 0, 0, 0, 1, 32'h44, 0, '0, 0);
    step(1, 0, 0, 0, 0, '0, 0, '0, 0);
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(199) == 0, $urandom_range(19) == 0, $urandom_range(11) == 0,
           $urandom_range(3) == 0, $urandom_range(3) == 0, W'($urandom_range(32'hFFF)),
           $urandom_range(3) == 0, W'($urandom_range(32'hFFF)), $urandom_range(2) == 0);
    end
    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL resp_leftover got=%0d entries want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
